// File: rtl/fighter_pkg.sv
// fighter_pkg: types and defaults shared by the per-player hit logic.
// Holds the reaction state encoding and knockback vector width.
package fighter_pkg;

  localparam int KB_W          = 8;
  localparam int DMG_LIGHT_DEF = 8;
  localparam int DMG_HEAVY_DEF = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    SLIDE   = 3'd2,
    RECOVER = 3'd3,
    KO      = 3'd4
  } react_state_t;

endpackage

// File: rtl/kb_axis_step.sv
// kb_axis_step: one axis of position + velocity with range clamp.
// wall_o flags that the result sits on (or was pushed past) a bound.
module kb_axis_step
  import fighter_pkg::*;
#(
  parameter int W = 12
) (
  input  logic signed [W-1:0]    pos_i,
  input  logic signed [KB_W-1:0] vel_i,
  input  logic signed [W-1:0]    lo_i,
  input  logic signed [W-1:0]    hi_i,
  output logic signed [W-1:0]    pos_o,
  output logic                   wall_o
);

  logic signed [W-1:0] sum;

  // add sign-extended velocity, then clamp to [lo, hi]
  always_comb begin
    sum    = pos_i + {{(W-KB_W){vel_i[KB_W-1]}}, vel_i};
    pos_o  = sum;
    wall_o = 1'b0;
    if (sum <= lo_i) begin
      pos_o  = lo_i;
      wall_o = 1'b1;
    end else if (sum >= hi_i) begin
      pos_o  = hi_i;
      wall_o = 1'b1;
    end
  end

endmodule

// File: rtl/hit_reaction.sv
// hit_reaction: per-player consumer of resolver hit outputs.
// Applies damage, integrates knockback and sequences launch/slide/recover/KO.
module hit_reaction
  import fighter_pkg::*;
#(
  parameter int POS_WIDTH       = 10,
  parameter int HP_MAX          = 100,
  parameter int DMG_LIGHT       = DMG_LIGHT_DEF,
  parameter int DMG_HEAVY       = DMG_HEAVY_DEF,
  parameter int GRAVITY         = 1,
  parameter int VY_MAX          = 8,
  parameter int FRICTION_FRAMES = 2,
  parameter int GROUND_Y        = 400,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int RECOVER_FRAMES  = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   SCEN,
  input  logic                   round_start,
  input  logic                   hit_event,
  input  logic                   hitstun_active,
  input  logic                   hit_heavy,
  input  logic signed [KB_W-1:0] kb_dx,
  input  logic signed [KB_W-1:0] kb_dy,
  input  logic [POS_WIDTH-1:0]   pos_x_in,
  input  logic [POS_WIDTH-1:0]   pos_y_in,
  output logic [POS_WIDTH-1:0]   pos_x_out,
  output logic [POS_WIDTH-1:0]   pos_y_out,
  output logic                   pos_override,
  output logic                   input_lock,
  output logic [7:0]             hp,
  output logic                   ko,
  output logic [2:0]             react_state
);

  localparam int W = POS_WIDTH + 2;
  localparam logic signed [W-1:0] GY  = W'(GROUND_Y);
  localparam logic signed [W-1:0] XLO = W'(X_MIN);
  localparam logic signed [W-1:0] XHI = W'(X_MAX);
  localparam logic signed [W-1:0] YLO = '0;
  localparam logic signed [W-1:0] YHI = W'((1 << POS_WIDTH) - 1);
  localparam logic signed [KB_W:0] VYM = (KB_W+1)'(VY_MAX);

  react_state_t st_q, st_d;
  logic [7:0] hp_q, hp_d, dmg;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, x_nx, y_nx, y_lat;
  logic signed [KB_W-1:0] vx_q, vx_d, vy_q, vy_d, vy_inc;
  logic signed [KB_W:0] vy_sum;
  logic [7:0] fc_q, fc_d, rc_q, rc_d;
  logic x_wall, y_wall;

  kb_axis_step #(.W(W)) u_x (
    .pos_i (x_q),
    .vel_i (vx_q),
    .lo_i  (XLO),
    .hi_i  (XHI),
    .pos_o (x_nx),
    .wall_o(x_wall)
  );

  kb_axis_step #(.W(W)) u_y (
    .pos_i (y_q),
    .vel_i (vy_q),
    .lo_i  (YLO),
    .hi_i  (YHI),
    .pos_o (y_nx),
    .wall_o(y_wall)
  );

  // next state: round_start beats hit_event beats progression
  always_comb begin
    st_d   = st_q;
    hp_d   = hp_q;
    x_d    = x_q;
    y_d    = y_q;
    vx_d   = vx_q;
    vy_d   = vy_q;
    fc_d   = fc_q;
    rc_d   = rc_q;
    y_lat  = y_q;
    dmg    = hit_heavy ? 8'(DMG_HEAVY) : 8'(DMG_LIGHT);
    vy_sum = {vy_q[KB_W-1], vy_q} + (KB_W+1)'(GRAVITY);
    vy_inc = (vy_sum > VYM) ? VYM[KB_W-1:0] : vy_sum[KB_W-1:0];
    if (round_start) begin
      st_d = IDLE;
      hp_d = 8'(HP_MAX);
      vx_d = '0;
      vy_d = '0;
      fc_d = '0;
      rc_d = '0;
    end else if (hit_event && st_q != KO) begin
      hp_d = (hp_q > dmg) ? hp_q - dmg : 8'd0;
      if (st_q == IDLE || st_q == RECOVER) begin
        x_d   = {2'b00, pos_x_in};
        y_lat = {2'b00, pos_y_in};
      end
      y_d  = y_lat;
      vx_d = kb_dx;
      vy_d = kb_dy;
      fc_d = '0;
      rc_d = '0;
      st_d = (kb_dy[KB_W-1] || y_lat < GY) ? LAUNCH : SLIDE;
    end else begin
      unique case (st_q)
        LAUNCH: begin
          x_d  = x_nx;
          y_d  = y_nx;
          vx_d = x_wall ? '0 : vx_q;
          vy_d = vy_inc;
          if (y_nx >= GY && !vy_q[KB_W-1]) begin
            y_d  = GY;
            vy_d = '0;
            fc_d = '0;
            st_d = SLIDE;
          end
        end
        SLIDE: begin
          if (vx_q == '0) begin
            if (!hitstun_active) begin
              if (hp_q == 8'd0) begin
                st_d = KO;
              end else begin
                st_d = RECOVER;
                rc_d = 8'(RECOVER_FRAMES);
              end
            end
          end else begin
            x_d = x_nx;
            if (fc_q >= 8'(FRICTION_FRAMES - 1)) begin
              fc_d = '0;
              vx_d = vx_q[KB_W-1] ? vx_q + 8'sd1 : vx_q - 8'sd1;
            end else begin
              fc_d = fc_q + 8'd1;
            end
            if (x_wall) vx_d = '0;
          end
        end
        RECOVER: begin
          rc_d = rc_q - 8'd1;
          if (rc_q <= 8'd1) begin
            rc_d = '0;
            st_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // frame-enabled state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= IDLE;
      hp_q <= 8'(HP_MAX);
      x_q  <= '0;
      y_q  <= '0;
      vx_q <= '0;
      vy_q <= '0;
      fc_q <= '0;
      rc_q <= '0;
    end else if (SCEN) begin
      st_q <= st_d;
      hp_q <= hp_d;
      x_q  <= x_d;
      y_q  <= y_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      fc_q <= fc_d;
      rc_q <= rc_d;
    end
  end

  assign pos_x_out    = x_q[POS_WIDTH-1:0];
  assign pos_y_out    = y_q[POS_WIDTH-1:0];
  assign pos_override = (st_q == LAUNCH) || (st_q == SLIDE);
  assign input_lock   = (st_q != IDLE);
  assign ko           = (st_q == KO);
  assign hp           = hp_q;
  assign react_state  = st_q;

endmodule

// File: tb/tb_hit_reaction.sv
// tb_hit_reaction: directed bench for hit_reaction.
// Linear step sequence with hand-computed expected values.
module tb_hit_reaction;

  logic clk = 1'b0;
  logic reset_n, SCEN, round_start, hit_event;
  logic hitstun_active, hit_heavy;
  logic signed [7:0] kb_dx, kb_dy;
  logic [9:0] pos_x_in, pos_y_in, pos_x_out, pos_y_out;
  logic pos_override, input_lock, ko;
  logic [7:0] hp;
  logic [2:0] react_state;

  int checks = 0;
  int errors = 0;

  hit_reaction dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .SCEN          (SCEN),
    .round_start   (round_start),
    .hit_event     (hit_event),
    .hitstun_active(hitstun_active),
    .hit_heavy     (hit_heavy),
    .kb_dx         (kb_dx),
    .kb_dy         (kb_dy),
    .pos_x_in      (pos_x_in),
    .pos_y_in      (pos_y_in),
    .pos_x_out     (pos_x_out),
    .pos_y_out     (pos_y_out),
    .pos_override  (pos_override),
    .input_lock    (input_lock),
    .hp            (hp),
    .ko            (ko),
    .react_state   (react_state)
  );

  always #5 clk = ~clk;

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, int'(pos_x_out), ex);
    chk({tag, "_y"}, int'(pos_y_out), ey);
  endtask

  task automatic hit(input int px, input int py, input int dx,
                     input int dy, input logic heavy);
    pos_x_in  = 10'(px);
    pos_y_in  = 10'(py);
    kb_dx     = 8'(dx);
    kb_dy     = 8'(dy);
    hit_heavy = heavy;
    hit_event = 1'b1;
    frame(1);
    hit_event = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; SCEN = 1'b1; round_start = 1'b0;
    hit_event = 1'b0; hitstun_active = 1'b0; hit_heavy = 1'b0;
    kb_dx = '0; kb_dy = '0; pos_x_in = '0; pos_y_in = '0;
    frame(2);
    reset_n = 1'b1;
    frame(2);
    // 1: reset / idle
    chk("rst_hp", int'(hp), 100);
    chk("rst_ko", int'(ko), 0);
    chk("rst_ovr", int'(pos_override), 0);
    chk("rst_lock", int'(input_lock), 0);
    chk("rst_state", int'(react_state), 0);
    chk_pos("rst_pos", 0, 0);

    // 2: light launch from ground
    hit(100, 400, 3, -2, 1'b0);
    chk("l_state", int'(react_state), 1);
    chk("l_hp", int'(hp), 92);
    chk_pos("l_f0", 100, 400);
    chk("l_ovr", int'(pos_override), 1);
    frame(1); chk_pos("l_f1", 103, 398);
    frame(1); chk_pos("l_f2", 106, 397);
    frame(1); chk_pos("l_f3", 109, 397);
    frame(1); chk_pos("l_f4", 112, 398);
    frame(1); chk_pos("l_f5", 115, 400);
    chk("land_state", int'(react_state), 2);

    // 3: slide with friction, hitstun hold, recover
    frame(6);
    chk("slide_x", int'(pos_x_out), 127);
    chk("slide_state", int'(react_state), 2);
    hitstun_active = 1'b1;
    frame(2);
    chk("stun_hold", int'(react_state), 2);
    chk("stun_x", int'(pos_x_out), 127);
    hitstun_active = 1'b0;
    frame(1);
    chk("rec_state", int'(react_state), 3);
    chk("rec_ovr", int'(pos_override), 0);
    chk("rec_lock", int'(input_lock), 1);
    hitstun_active = 1'b1;
    frame(5);
    chk("rec_last", int'(react_state), 3);
    frame(1);
    hitstun_active = 1'b0;
    chk("idle_state", int'(react_state), 0);
    chk("idle_lock", int'(input_lock), 0);

    // 4: heavy hit into right wall
    hit(635, 400, 5, 0, 1'b1);
    chk("w_state", int'(react_state), 2);
    chk("w_hp", int'(hp), 77);
    frame(1);
    chk("w_x", int'(pos_x_out), 639);
    frame(1);
    chk("w_rec", int'(react_state), 3);
    round_start = 1'b1;
    frame(1);
    round_start = 1'b0;
    chk("rs_hp", int'(hp), 100);
    chk("rs_state", int'(react_state), 0);

    // 5: drain HP, juggle, KO
    for (int i = 0; i < 6; i++) hit(300, 400, 2, 0, 1'b1);
    chk("drain_hp", int'(hp), 10);
    hit(300, 400, 2, 0, 1'b1);
    chk("zero_hp", int'(hp), 0);
    chk("zero_state", int'(react_state), 2);
    frame(4);
    chk("ko_slide_x", int'(pos_x_out), 306);
    frame(1);
    chk("ko_state", int'(react_state), 4);
    chk("ko_flag", int'(ko), 1);
    chk("ko_lock", int'(input_lock), 1);
    hit(300, 400, 2, 0, 1'b0);
    chk("ko_hit_state", int'(react_state), 4);
    chk("ko_hit_hp", int'(hp), 0);
    round_start = 1'b1;
    frame(1);
    round_start = 1'b0;
    chk("ko_rs_hp", int'(hp), 100);
    chk("ko_rs_ko", int'(ko), 0);
    chk("ko_rs_state", int'(react_state), 0);

    // 6a: round_start drops simultaneous hit
    hit(300, 400, 0, 0, 1'b0);
    chk("pre_hp", int'(hp), 92);
    round_start = 1'b1;
    hit(300, 400, 0, 0, 1'b1);
    round_start = 1'b0;
    chk("rs_hit_hp", int'(hp), 100);
    chk("rs_hit_state", int'(react_state), 0);

    // 6b: SCEN freeze mid-launch
    hit(200, 400, 1, -4, 1'b0);
    frame(1);
    chk_pos("fz_pre", 201, 396);
    SCEN = 1'b0;
    frame(3);
    chk_pos("fz_hold", 201, 396);
    chk("fz_state", int'(react_state), 1);
    SCEN = 1'b1;
    frame(1);
    chk_pos("fz_go", 202, 393);

    // 6c: async reset mid-launch
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_hp", int'(hp), 100);
    chk("ar_state", int'(react_state), 0);
    chk("ar_ovr", int'(pos_override), 0);
    chk("ar_lock", int'(input_lock), 0);
    chk("ar_ko", int'(ko), 0);
    chk_pos("ar_pos", 0, 0);
    frame(1);
    reset_n = 1'b1;
    frame(2);
    chk_pos("ar_after", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_reaction.md
Name: hit_reaction

Overview:
- Per-player consumer of resolver outputs: hit pulse, hitstun flag and knockback vector.
- Applies damage to HP and integrates knockback into a position override with gravity, ground friction and wall clamps.
- Sequences the player through launch, slide, recover and KO, and gates player_state input via input_lock.
- One instance per player, sitting between the resolver and the player movement/state logic.

Parameters:
POS_WIDTH, 10, position coordinate width
HP_MAX, 100, HP on reset and round start
DMG_LIGHT, 8, HP lost per light hit
DMG_HEAVY, 15, HP lost per heavy hit
GRAVITY, 1, vy increment per frame while airborne
VY_MAX, 8, terminal fall speed
FRICTION_FRAMES, 2, frames per 1-unit decay of |vx| while sliding
GROUND_Y, 400, floor y (feet)
X_MIN, 0, left wall
X_MAX, 639, right wall
RECOVER_FRAMES, 6, post-slide lockout frames

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
SCEN  in  1  frame-rate enable; all state advances only when high
round_start  in  1  resets HP and state (sampled on SCEN)
hit_event  in  1  1-SCEN pulse, new hit from resolver
hitstun_active  in  1  resolver stun flag
hit_heavy  in  1  hit strength; valid with hit_event
kb_dx  in  8 signed  knockback x velocity
kb_dy  in  8 signed  knockback y velocity (negative = up)
pos_x_in  in  POS_WIDTH  current player x from movement
pos_y_in  in  POS_WIDTH  current player y
pos_x_out  out  POS_WIDTH  override x
pos_y_out  out  POS_WIDTH  override y
pos_override  out  1  movement must adopt pos_*_out
input_lock  out  1  player_state must ignore controls
hp  out  8  current HP
ko  out  1  player knocked out
react_state  out  3  IDLE/LAUNCH/SLIDE/RECOVER/KO encoding

Behaviour:
- Reset (async, reset_n low): state IDLE; hp=HP_MAX; ko=0; pos_*_out=0; pos_override=0; input_lock=0; internal vx, vy, counters 0.
- All transitions occur on the clk edge with SCEN=1. With SCEN=0, every register holds.
- Priority per frame: round_start, then hit_event, then state progression.
- round_start, any state: hp=HP_MAX, ko=0, state IDLE, velocities 0. A hit in the same frame is dropped.
- hit_event in IDLE/LAUNCH/SLIDE/RECOVER:
  - hp -= DMG (saturates at 0).
  - Latch x,y: from pos_*_in when coming from IDLE/RECOVER; keep current override when already LAUNCH/SLIDE (juggle).
  - vx=kb_dx, vy=kb_dy.
  - Next state LAUNCH if kb_dy<0 or y<GROUND_Y, else SLIDE.
  - Output changes visible the cycle after the hit frame (1 SCEN latency).
- hit_event in KO: ignored.
- Position arithmetic is signed, POS_WIDTH+2 bits internally; outputs are the clamped low bits.
- LAUNCH, each frame:
  - x+=vx, y+=vy, then vy=min(vy+GRAVITY, VY_MAX).
  - y clamped at ≥0.
  - If new y≥GROUND_Y and vy≥0 before the increment: y=GROUND_Y, vy=0, go to SLIDE.
- SLIDE, each frame:
  - x+=vx; a friction counter decays |vx| by 1 every FRICTION_FRAMES frames.
  - When vx==0 and hitstun_active==0: go KO if hp==0, else RECOVER with counter=RECOVER_FRAMES.
- Walls, in LAUNCH and SLIDE: x clamped to [X_MIN,X_MAX]; reaching a wall zeroes vx that frame.
- RECOVER: counter decrements; at 0 go IDLE. hitstun_active does not extend it.
- KO: ko=1, holds until round_start.
- Outputs:
  - pos_override=1 in LAUNCH and SLIDE.
  - input_lock=1 in every state except IDLE.
  - hp is unaffected by everything except hits, round_start and reset.
- Reset mid-operation: immediate IDLE with full HP; no residual velocity.

Decomposition:
- Shared package fighter_pkg holds:
  - react_state_t enum: IDLE=0, LAUNCH=1, SLIDE=2, RECOVER=3, KO=4.
  - DMG_LIGHT/DMG_HEAVY defaults.
  - Signed knockback vector width (8).
- One sub-module, kb_axis_step: one axis of position+velocity add with min/max clamp and a wall-hit flag. Instantiated twice, for x and y.

Test Plan:
1. Reset, then idle frames → hp=100, ko=0, pos_override=0, input_lock=0, react_state=IDLE.
2. Light hit, pos_in=(100,400), kb=(+3,-2), GRAVITY=1:
   - Outputs after frames 1–4: (103,398), (106,397), (109,397), (112,398).
   - Frame 5: y=400 → SLIDE; hp=92.
3. Slide from vx=+3, FRICTION_FRAMES=2, hitstun low → vx hits 0 after 6 frames → RECOVER for 6 frames (input_lock=1) → IDLE, pos_override=0.
4. Heavy hit, x=635, kb=(+5,0) → SLIDE; x clamps to 639, vx=0 → RECOVER next frame.
5. hp=10 plus heavy hit → hp=0, slides out → KO, ko=1. A further hit_event leaves state unchanged; round_start → hp=100, IDLE.
6. Simultaneous:
   - round_start + hit_event → hit dropped, hp=100.
   - SCEN=0 during LAUNCH → outputs frozen.
   - reset_n low mid-LAUNCH → all outputs at reset values asynchronously.
